// File: rtl/tbcc_rep_encoder.sv
// Tail-biting convolutional encoder with run-time repetition.
// Buffers L info bits, encodes at rate 1/N, then streams the coded block R times.
module tbcc_rep_encoder #(
  parameter int                 L     = 32,
  parameter int                 K     = 7,
  parameter int                 N     = 3,
  parameter logic [N*K-1:0]     G     = {7'o133, 7'o171, 7'o165},
  parameter int                 REP_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din,
  input  logic             din_vld,
  output logic             din_rdy,
  input  logic [REP_W-1:0] rep_num,
  output logic             dout,
  output logic             dout_vld,
  input  logic             dout_rdy,
  output logic             dout_last,
  output logic             busy
);

  // state  | meaning
  // S_LOAD | accepting L info bits into d_buf
  // S_ENC  | one info position per cycle, N coded bits written to c_mem
  // S_OUT  | streaming c_mem R times; first cycle primes dout_vld

  localparam int CW = (L > 1) ? $clog2(L) : 1;
  localparam int BW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST_W = CW'(L - 1);
  localparam logic [BW-1:0] LAST_B = BW'(N - 1);

  typedef enum logic [1:0] {S_LOAD, S_ENC, S_OUT} state_t;

  state_t           state, state_d;
  logic [L-1:0]     d_buf;
  logic [N-1:0]     c_mem [L];
  logic [CW-1:0]    load_cnt;
  logic [CW-1:0]    enc_cnt;
  logic [CW-1:0]    rd_word;
  logic [BW-1:0]    rd_bit;
  logic [REP_W-1:0] rep_cnt;
  logic [REP_W-1:0] rep_max;
  logic [K-1:0]     win;
  logic [N-1:0]     enc_bits;
  logic             take, give, last_bit, last_rep;

  assign din_rdy   = (state == S_LOAD);
  assign busy      = (state != S_LOAD);
  assign take      = din_vld & din_rdy;
  assign give      = dout_vld & dout_rdy;
  assign last_bit  = (rd_word == LAST_W) && (rd_bit == LAST_B);
  assign last_rep  = (rep_cnt == rep_max - REP_W'(1));
  assign dout      = dout_vld & c_mem[rd_word][rd_bit];
  assign dout_last = dout_vld & last_bit & last_rep;

  // Window tap i reads d[(n-i) mod L]; the wrap gives the tail-biting start state.
  always_comb begin
    win = '0;
    for (int i = 0; i < K; i++) begin
      int t;
      t = int'(enc_cnt) - i;
      if (t < 0) t = t + L;
      win[i] = d_buf[t[CW-1:0]];
    end
    enc_bits = '0;
    for (int j = 0; j < N; j++)
      for (int i = 0; i < K; i++)
        enc_bits[j] = enc_bits[j] ^ (win[i] & G[(N-1-j)*K + (K-1-i)]);
  end

  always_comb begin
    state_d = state;
    case (state)
      S_LOAD: if (take && load_cnt == LAST_W) state_d = S_ENC;
      S_ENC:  if (enc_cnt == LAST_W) state_d = S_OUT;
      S_OUT:  if (give && last_bit && last_rep) state_d = S_LOAD;
      default: state_d = S_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_LOAD;
      load_cnt <= '0;
      enc_cnt  <= '0;
      rd_word  <= '0;
      rd_bit   <= '0;
      rep_cnt  <= '0;
      rep_max  <= REP_W'(1);
      dout_vld <= 1'b0;
    end else begin
      state <= state_d;
      case (state)
        S_LOAD: begin
          if (take) begin
            load_cnt <= (load_cnt == LAST_W) ? '0 : load_cnt + CW'(1);
            if (load_cnt == '0)
              rep_max <= (rep_num == '0) ? REP_W'(1) : rep_num;
          end
        end
        S_ENC: enc_cnt <= (enc_cnt == LAST_W) ? '0 : enc_cnt + CW'(1);
        S_OUT: begin
          if (!dout_vld) begin
            dout_vld <= 1'b1;
          end else if (dout_rdy) begin
            if (last_bit) begin
              rd_word <= '0;
              rd_bit  <= '0;
              if (last_rep) begin
                rep_cnt  <= '0;
                dout_vld <= 1'b0;
              end else begin
                rep_cnt <= rep_cnt + REP_W'(1);
              end
            end else if (rd_bit == LAST_B) begin
              rd_bit  <= '0;
              rd_word <= rd_word + CW'(1);
            end else begin
              rd_bit <= rd_bit + BW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Data buffers need no reset: every block overwrites them fully before use.
  always_ff @(posedge clk) begin
    if (state == S_LOAD && take) d_buf[load_cnt] <= din;
    if (state == S_ENC) c_mem[enc_cnt] <= enc_bits;
  end

endmodule

// File: tb/tb_tbcc_rep_encoder.sv
// Directed bench for tbcc_rep_encoder: vector table plus reset and back-to-back sequences.
module tb_tbcc_rep_encoder;
  localparam int L = 32;
  localparam int K = 7;
  localparam int N = 3;
  localparam int CB = N * L;

  logic       clk = 0;
  logic       rst_n, din, din_vld, din_rdy, dout, dout_vld, dout_rdy, dout_last, busy;
  logic [3:0] rep_num;
  int         cyc = 0;
  int         tests = 0;
  int         failed = 0;

  tbcc_rep_encoder dut (
    .clk(clk), .rst_n(rst_n), .din(din), .din_vld(din_vld), .din_rdy(din_rdy),
    .rep_num(rep_num), .dout(dout), .dout_vld(dout_vld), .dout_rdy(dout_rdy),
    .dout_last(dout_last), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit [L-1:0]  data;
    logic [3:0]  rep;
    bit          rnd;
    bit [CB-1:0] exp;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string nm, input longint act, input longint exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic bit [K-1:0] gen(input int j);
    case (j)
      0: return 7'o133;
      1: return 7'o171;
      default: return 7'o165;
    endcase
  endfunction

  // Shift-register encoder preloaded with the last K-1 bits of the block.
  function automatic bit [CB-1:0] model(input bit [L-1:0] d);
    bit [K-1:0]  sr = '0;
    bit [CB-1:0] c = '0;
    for (int k = 1; k < K; k++) sr[K-k] = d[L-k];
    for (int n = 0; n < L; n++) begin
      sr = {d[n], sr[K-1:1]};
      for (int j = 0; j < N; j++) c[n*N+j] = ^(sr & gen(j));
    end
    return c;
  endfunction

  task automatic send_block(input bit [L-1:0] data, input logic [3:0] rep, input bit hold,
                            output int t_last);
    for (int k = 0; k < L; k++) begin
      int w = 0;
      din = data[k];
      din_vld = 1;
      rep_num = (k == 0) ? rep : ~rep;
      while (!din_rdy && w < 500) begin @(posedge clk); #1; w++; end
      if (!din_rdy) chk("din_rdy_timeout", 0, 1);
      @(posedge clk); #1;
    end
    t_last = cyc;
    if (!hold) din_vld = 0;
    din = 1;
    rep_num = 4'hA;
  endtask

  task automatic collect(input bit [CB-1:0] exp, input int r, input bit rnd,
                         input int t_last, input bit chk_lat, input string nm);
    int   got = 0, bad = 0, lasts = 0, last_pos = -1, stall_bad = 0, rdy_bad = 0;
    int   cycles = 0, first_cyc = -1;
    bit   prev_stall = 0, done = 0;
    logic pd = 0, pl = 0;
    while (!done && cycles < 4000) begin
      if (prev_stall && (!dout_vld || dout !== pd || dout_last !== pl)) stall_bad++;
      if (din_rdy) rdy_bad++;
      if (dout_vld && first_cyc < 0) first_cyc = cyc;
      dout_rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (dout_vld && dout_rdy) begin
        if (dout !== exp[got % CB]) bad++;
        if (dout_last) begin lasts++; last_pos = got; done = 1; end
        got++;
      end
      prev_stall = dout_vld && !dout_rdy;
      pd = dout;
      pl = dout_last;
      @(posedge clk); #1;
      cycles++;
    end
    dout_rdy = 1;
    chk({nm, "_count"}, got, CB * r);
    chk({nm, "_bit_errors"}, bad, 0);
    chk({nm, "_last_count"}, lasts, 1);
    chk({nm, "_last_pos"}, last_pos, CB * r - 1);
    chk({nm, "_din_rdy_while_busy"}, rdy_bad, 0);
    if (rnd) chk({nm, "_stall_stability"}, stall_bad, 0);
    if (chk_lat) chk({nm, "_latency"}, first_cyc - t_last, L + 1);
    chk({nm, "_idle_vld_rdy_busy"}, {dout_vld, din_rdy, busy}, 3'b010);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int n, w, vcnt;
    vecs[0] = '{data: '0,            rep: 4'd2, rnd: 0, exp: '0};
    vecs[1] = '{data: 32'h1,         rep: 4'd1, rnd: 0, exp: 96'h1CC7F7};
    vecs[2] = '{data: 32'h8000_0000, rep: 4'd1, rnd: 0, exp: {4'hE, 72'h0, 20'h398FE}};
    vecs[3] = '{data: '1,            rep: 4'd1, rnd: 0, exp: '1};
    vecs[4] = '{data: 32'hA5C3_1E96, rep: 4'd3, rnd: 1, exp: model(32'hA5C3_1E96)};
    vecs[5] = '{data: 32'hDEAD_BEEF, rep: 4'd0, rnd: 1, exp: model(32'hDEAD_BEEF)};

    rst_n = 0; din = 0; din_vld = 0; rep_num = 0; dout_rdy = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_din_rdy", din_rdy, 1);
    chk("reset_dout_vld", dout_vld, 0);
    chk("reset_dout", dout, 0);
    chk("reset_dout_last", dout_last, 0);
    chk("reset_busy", busy, 0);
    rst_n = 1;
    @(posedge clk); #1;

    for (int v = 0; v < 6; v++) begin
      int r;
      r = (vecs[v].rep == 0) ? 1 : int'(vecs[v].rep);
      send_block(vecs[v].data, vecs[v].rep, 0, t);
      collect(vecs[v].exp, r, vecs[v].rnd, t, 1, $sformatf("vec%0d", v));
    end

    // Reset while bit 40 of the second repetition is on the output.
    send_block(32'hC0FF_EE11, 4'd2, 0, t);
    dout_rdy = 1;
    n = 0; w = 0;
    while (n < CB + 40 && w < 1000) begin
      if (dout_vld) n++;
      @(posedge clk); #1;
      w++;
    end
    chk("midout_reached", n, CB + 40);
    rst_n = 0;
    @(posedge clk); #1;
    chk("midout_rst_vld", dout_vld, 0);
    chk("midout_rst_rdy", din_rdy, 1);
    chk("midout_rst_busy", busy, 0);
    rst_n = 1;
    vcnt = 0;
    repeat (5) begin
      if (dout_vld) vcnt++;
      @(posedge clk); #1;
    end
    chk("midout_no_vld_after_rst", vcnt, 0);
    send_block(32'h1357_9BDF, 4'd1, 0, t);
    collect(model(32'h1357_9BDF), 1, 0, t, 1, "post_rst");

    // Back-to-back blocks, din_vld never dropped.
    send_block(32'h0F0F_3C3C, 4'd1, 1, t);
    collect(model(32'h0F0F_3C3C), 1, 0, t, 1, "b2b_a");
    send_block(32'h8421_7BDE, 4'd2, 1, t);
    collect(model(32'h8421_7BDE), 2, 0, t, 1, "b2b_b");
    din_vld = 0;

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
